// File: rtl/lsu_ram_master.sv
// Load/store initiator for a single-port byte-masked SRAM.
// Accepts one request at a time, drives one RAM access cycle, then holds the
// response (lane-extracted and extended load data, or an error) until taken.
module lsu_ram_master #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int MW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          ram_cs,
   output logic          ram_we,
   output logic [MW-1:0] ram_wem,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state, state_nxt;
   logic        accept;
   logic        legal;
   logic [1:0]  lane;
   logic [1:0]  size_p0;
   logic        uns_p0;
   logic [1:0]  lane_p0;

   // Byte write-enable pattern for a store of the given size at the given lane.
   function automatic logic [MW-1:0] lane_mask(input logic [1:0] size, input logic [1:0] ln);
      case (size)
         2'b00:   lane_mask = MW'(4'b0001 << ln);
         2'b01:   lane_mask = MW'(4'b0011 << ln);
         default: lane_mask = MW'(4'b1111);
      endcase
   endfunction

   // Replicates right-aligned store data across all byte lanes it could occupy.
   function automatic logic [DW-1:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
      case (size)
         2'b00:   lane_data = DW'({4{wd[7:0]}});
         2'b01:   lane_data = DW'({2{wd[15:0]}});
         default: lane_data = DW'(wd);
      endcase
   endfunction

   // Shifts the addressed lane down and sign- or zero-extends to 32 bits.
   function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                                input logic [1:0] ln, input logic [DW-1:0] dout);
      logic [31:0] d;
      d = 32'(dout) >> {ln, 3'b000};
      case (size)
         2'b00:   load_extract = {{24{~uns & d[7]}}, d[7:0]};
         2'b01:   load_extract = {{16{~uns & d[15]}}, d[15:0]};
         default: load_extract = d;
      endcase
   endfunction

   assign lane   = req_addr[1:0];
   assign accept = req_valid & req_ready;

   // Alignment/size legality of the presented request.
   always_comb begin
      legal = 1'b0;
      case (req_size)
         2'b00:   legal = 1'b1;
         2'b01:   legal = ~lane[0];
         2'b10:   legal = (lane == 2'b00);
         default: legal = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = legal ? ACCESS : RESP;
         end
         ACCESS: state_nxt = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // RAM drive (live only during ACCESS) and held response fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_cs    <= 1'b0;
         ram_we    <= 1'b0;
         ram_wem   <= '0;
         ram_addr  <= '0;
         ram_din   <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rsp_rdata <= '0;
                  rsp_err   <= ~legal;
                  if (legal) begin
                     ram_cs   <= 1'b1;
                     ram_we   <= req_we;
                     ram_wem  <= req_we ? lane_mask(req_size, lane) : '0;
                     ram_addr <= {req_addr[AW-1:2], 2'b00};
                     ram_din  <= req_we ? lane_data(req_size, req_wdata) : '0;
                  end
               end
            end
            ACCESS: begin
               ram_cs   <= 1'b0;
               ram_we   <= 1'b0;
               ram_wem  <= '0;
               ram_addr <= '0;
               ram_din  <= '0;
               if (!ram_we) rsp_rdata <= load_extract(size_p0, uns_p0, lane_p0, ram_dout);
            end
            default: ;
         endcase
      end
   end

   // Load-extraction context captured at acceptance; requester may change fields afterwards.
   always_ff @(posedge clk) begin
      if (accept) begin
         size_p0 <= req_size;
         uns_p0  <= req_unsigned;
         lane_p0 <= lane;
      end
   end

endmodule

// File: tb/tb_lsu_ram_master.sv
// Bench for lsu_ram_master: directed requests against a behavioural byte-masked
// RAM; expected RAM accesses and responses are queued by the driver and popped
// by a negedge monitor.
module tb_lsu_ram_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        ram_cs;
   logic        ram_we;
   logic [3:0]  ram_wem;
   logic [31:0] ram_addr;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [3:0]  wem;
      logic [31:0] addr;
      logic [31:0] din;
      bit          has_din;
   } ram_exp_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } rsp_exp_t;

   ram_exp_t ram_q[$];
   rsp_exp_t rsp_q[$];

   logic [31:0] mem [0:63];

   lsu_ram_master #(.AW(32), .DW(32), .MW(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_wem(ram_wem), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Behavioural RAM: combinational read, byte-masked write on the rising edge.
   assign ram_dout = mem[ram_addr[7:2]];
   always @(posedge clk) begin
      if (ram_cs && ram_we) begin
         for (int b = 0; b < 4; b++)
            if (ram_wem[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_din[8*b +: 8];
      end
   end

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every RAM access and every taken response must match the queued expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (ram_cs) begin
            if (ram_q.size() == 0) begin
               chk("unexpected_ram_cs", 72'(ram_addr), 72'hFFFF_FFFF_FFFF);
            end else begin
               ram_exp_t e;
               e = ram_q.pop_front();
               chk("ram_ctl", 72'({ram_we, ram_wem, ram_addr}), 72'({e.we, e.wem, e.addr}));
               if (e.has_din) chk("ram_din", 72'(ram_din), 72'(e.din));
            end
         end else begin
            chk("ram_idle_zero", 72'({ram_we, ram_wem, ram_addr, ram_din}), 72'd0);
         end
         if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) begin
               chk("unexpected_rsp", 72'(rsp_rdata), 72'hFFFF_FFFF_FFFF);
            end else begin
               rsp_exp_t r;
               r = rsp_q.pop_front();
               chk("rsp", 72'({rsp_err, rsp_rdata}), 72'({r.err, r.rdata}));
            end
         end
      end
   end

   // Issue one request starting just after a rising edge; waits out its response.
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [3:0] exp_wem, input logic [31:0] exp_din,
                         input int hold);
      ram_exp_t re;
      rsp_exp_t rs;
      int lat;
      int exp_lat;
      logic [31:0] held;
      exp_lat = exp_err ? 1 : 2;
      if (!exp_err) begin
         re.we = we; re.wem = exp_wem; re.addr = {addr[31:2], 2'b00};
         re.din = exp_din; re.has_din = we;
         ram_q.push_back(re);
      end
      rs.rdata = exp_rdata; rs.err = exp_err;
      rsp_q.push_back(rs);
      rsp_ready    = (hold == 0);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      @(negedge clk);
      chk("req_ready_idle", 72'(req_ready), 72'd1);
      @(posedge clk);
      #1;
      req_valid    = 1'b0;
      req_we       = ~we;
      req_size     = ~size;
      req_unsigned = ~uns;
      req_addr     = ~addr;
      req_wdata    = ~wdata;
      for (lat = 1; lat <= 8; lat++) begin
         @(negedge clk);
         if (rsp_valid) break;
         @(posedge clk);
      end
      chk("rsp_latency", 72'(lat), 72'(exp_lat));
      chk("req_ready_busy", 72'(req_ready), 72'd0);
      if (hold > 0) begin
         held = rsp_rdata;
         repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_stable", 72'({rsp_valid, req_ready, rsp_rdata}), 72'({1'b1, 1'b0, held}));
         end
         @(posedge clk);
         #1 rsp_ready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      chk("back_to_idle", 72'({req_ready, rsp_valid}), 72'b10);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
      #12;
      chk("reset_outputs", 72'({ram_cs, ram_we, ram_wem, ram_addr, rsp_valid, rsp_err}), 72'd0);
      chk("reset_data", 72'({ram_din, rsp_rdata}), 72'd0);
      chk("reset_ready", 72'(req_ready), 72'd1);
      @(posedge clk);
      #1 rst = 1'b0;

      // Word store/load
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111, 32'hDEADBEEF, 0);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000, 32'h0, 0);
      // Byte store at lane 3, signed and unsigned loads
      do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h123456A5, 32'h0, 1'b0, 4'b1000, 32'hA5A5A5A5, 0);
      do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFA5, 1'b0, 4'b0000, 32'h0, 0);
      do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000A5, 1'b0, 4'b0000, 32'h0, 0);
      // Word now A5ADBEEF; byte lane 1 signed -> FFFFFFBE, half lane 0 unsigned -> 0000BEEF
      do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0, 4'b0000, 32'h0, 0);
      do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 4'b0000, 32'h0, 0);
      // Half store at lane 2, signed loads
      do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hCAFE8001, 32'h0, 1'b0, 4'b1100, 32'h80018001, 0);
      do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 4'b0000, 32'h0, 0);
      do_req(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 32'h00000001, 1'b0, 4'b0000, 32'h0, 0);
      // Misaligned / illegal requests
      do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 0);
      do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 0);
      do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 0);
      do_req(1'b1, 2'b01, 1'b0, 32'h23, 32'hFFFFFFFF, 32'h0, 1'b1, 4'b0000, 32'h0, 0);
      // Back-pressure on the response
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 4'b0000, 32'h0, 5);
      // Top address passes through
      do_req(1'b0, 2'b10, 1'b0, 32'hFFFFFF10, 32'h0, 32'hA5ADBEEF, 1'b0, 4'b0000, 32'h0, 0);

      // Reset during ACCESS suppresses the write and drops the response
      do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'h11111111, 32'h0, 1'b0, 4'b1111, 32'h11111111, 0);
      begin
         ram_exp_t re;
         re.we = 1'b1; re.wem = 4'b1111; re.addr = 32'h30; re.din = 32'h22222222; re.has_din = 1'b1;
         ram_q.push_back(re);
      end
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h30; req_wdata = 32'h22222222;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("access_cs", 72'(ram_cs), 72'd1);
      #1 rst = 1'b1;
      #1;
      chk("rst_drops_cs", 72'({ram_cs, ram_we, rsp_valid}), 72'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      chk("ready_after_rst", 72'(req_ready), 72'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("no_rsp_after_rst", 72'(rsp_valid), 72'd0);
      do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h11111111, 1'b0, 4'b0000, 32'h0, 0);

      repeat (2) @(posedge clk);
      chk("queues_drained", 72'({ram_q.size(), rsp_q.size()}), 72'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
